// File: rtl/encd_bist_ctrl_if.sv
// encd_bist_ctrl_if: control, status and encoder-under-test signals of the BIST controller
interface encd_bist_ctrl_if #(parameter int IN_W = 10, parameter int OUT_W = 4);
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic pass;
  logic fail_vld;
  logic [IN_W-1:0] enc_in;
  logic [IN_W-1:0] err_cnt;
  logic [IN_W-1:0] first_fail_pat;
  logic [OUT_W-1:0] enc_out;
  logic [OUT_W-1:0] first_fail_val;
  modport master (
    output start, abort, enc_out,
    input  enc_in, busy, done, pass, err_cnt, fail_vld, first_fail_pat, first_fail_val
  );
  modport slave (
    input  start, abort, enc_out,
    output enc_in, busy, done, pass, err_cnt, fail_vld, first_fail_pat, first_fail_val
  );
endinterface

// File: rtl/encd_bist_ctrl.sv
// encd_bist_ctrl: exhaustive sweep of every non-zero pattern through a priority encoder, checking each result
module encd_bist_ctrl #(
  parameter int IN_W   = 10,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst_n,
  encd_bist_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
  state_t state, nxt;
  logic [IN_W-1:0] pat;
  logic [3:0] cnt;
  logic [OUT_W-1:0] gold;
  logic go, mis, last, run;
  assign go   = (state == IDLE || state == DONE) && bus.start && !bus.abort;
  assign mis  = state == CHECK && !bus.abort && bus.enc_out != gold;
  assign last = pat == '1;
  assign run  = nxt == APPLY || nxt == WAIT || nxt == CHECK;
  // reference result: index of the highest set bit of the current pattern
  always_comb begin
    gold = '0;
    for (int i = 0; i < IN_W; i++) gold = pat[i] ? OUT_W'(i) : gold;
  end
  // next state; abort wins over everything, including a simultaneous start
  always_comb begin
    nxt = bus.abort ? IDLE :
          (state == IDLE || state == DONE) ? (bus.start ? APPLY : state) :
          state == APPLY ? ((SETTLE > 0) ? WAIT : CHECK) :
          state == WAIT  ? (cnt == 4'd1 ? CHECK : WAIT) :
          state == CHECK ? (last ? DONE : APPLY) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // pattern walk, settle timer, drive to the encoder and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat                <= '0;
      cnt                <= '0;
      bus.enc_in         <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.fail_vld       <= 1'b0;
      bus.err_cnt        <= '0;
      bus.first_fail_pat <= '0;
      bus.first_fail_val <= '0;
    end else begin
      if (go) begin
        pat                <= IN_W'(1);
        bus.pass           <= 1'b0;
        bus.fail_vld       <= 1'b0;
        bus.err_cnt        <= '0;
        bus.first_fail_pat <= '0;
        bus.first_fail_val <= '0;
      end else if (state == CHECK && !bus.abort) begin
        pat <= last ? pat : pat + IN_W'(1);
        if (mis && bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + IN_W'(1);
        if (mis && !bus.fail_vld) begin
          bus.fail_vld       <= 1'b1;
          bus.first_fail_pat <= pat;
          bus.first_fail_val <= bus.enc_out;
        end
        if (last) bus.pass <= bus.err_cnt == '0 && !mis;
      end
      cnt        <= state == APPLY ? 4'(SETTLE) : state == WAIT ? cnt - 4'd1 : cnt;
      bus.enc_in <= nxt == APPLY ? (go ? IN_W'(1) : pat + IN_W'(1)) : run ? bus.enc_in : '0;
      bus.busy   <= run;
      bus.done   <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_encd_bist_ctrl.sv
// tb_encd_bist_ctrl: randomized fault-injection bench for encd_bist_ctrl at SETTLE=2 and SETTLE=0
module tb_encd_bist_ctrl;
  localparam int IN_W = 10;
  localparam int OUT_W = 4;
  localparam int NP = (1 << IN_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int ovr [1 << IN_W];
  encd_bist_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) i0 ();
  encd_bist_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) i1 ();
  encd_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  encd_bist_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  always #5 clk = ~clk;
  function automatic int golden(int p);
    return $clog2(p + 1) - 1;
  endfunction
  function automatic logic [OUT_W-1:0] enc(logic [IN_W-1:0] p);
    return ovr[p] < 0 ? OUT_W'(golden(int'(p))) : OUT_W'(ovr[p]);
  endfunction
  assign i0.enc_out = enc(i0.enc_in);
  assign i1.enc_out = enc(i1.enc_in);
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_all(int v);
    foreach (ovr[i]) ovr[i] = v;
  endtask
  task automatic expect_res(output int e, output int fp, output int fv);
    e = 0; fp = 0; fv = 0;
    for (int p = 1; p <= NP; p++) begin
      int o = ovr[p] < 0 ? golden(p) : ovr[p];
      if (o != golden(p)) begin
        if (e == 0) begin fp = p; fv = o; end
        e++;
      end
    end
    if (e > NP) e = NP;
  endtask
  task automatic set_start(logic v);
    i0.start = v;
    i1.start = v;
  endtask
  task automatic set_abort(logic v);
    i0.abort = v;
    i1.abort = v;
  endtask
  task automatic run_sweep(string tag, bit inject);
    int c = 0, d0 = -1, d1 = -1, e, fp, fv;
    expect_res(e, fp, fv);
    @(negedge clk);
    set_start(1'b1);
    while ((d0 < 0 || d1 < 0) && c < 10000) begin
      @(negedge clk);
      c++;
      if (c == 1) chk({tag, "_busy"}, {i0.busy, i1.busy}, 2'b11);
      set_start(inject && c == 300);
      if (d0 < 0 && i0.done) d0 = c - 1;
      if (d1 < 0 && i1.done) d1 = c - 1;
    end
    chk({tag, "_cyc_s2"}, d0, NP * 4);
    chk({tag, "_cyc_s0"}, d1, NP * 2);
    chk({tag, "_err_s2"}, i0.err_cnt, e);
    chk({tag, "_err_s0"}, i1.err_cnt, e);
    chk({tag, "_pass"}, {i0.pass, i1.pass}, {2{e == 0}});
    chk({tag, "_fvld"}, {i0.fail_vld, i1.fail_vld}, {2{e != 0}});
    chk({tag, "_ffp"}, {i0.first_fail_pat, i1.first_fail_pat}, {IN_W'(fp), IN_W'(fp)});
    chk({tag, "_ffv"}, {i0.first_fail_val, i1.first_fail_val}, {OUT_W'(fv), OUT_W'(fv)});
    chk({tag, "_idle"}, {i0.busy, i1.busy, i0.enc_in, i1.enc_in}, '0);
  endtask
  initial begin
    int c;
    set_start(1'b0);
    set_abort(1'b0);
    set_all(-1);
    repeat (3) @(negedge clk);
    chk("rst_s2", {i0.busy, i0.done, i0.pass, i0.fail_vld, i0.err_cnt, i0.first_fail_pat, i0.first_fail_val, i0.enc_in}, '0);
    chk("rst_s0", {i1.busy, i1.done, i1.pass, i1.fail_vld, i1.err_cnt, i1.first_fail_pat, i1.first_fail_val, i1.enc_in}, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_quiet", {i0.busy, i1.busy, i0.enc_in, i1.enc_in}, '0);
    run_sweep("clean", 1'b0);
    set_all(-1);
    ovr[11] = 15;
    run_sweep("trig11", 1'b1);
    set_all(0);
    run_sweep("stuck0", 1'b0);
    for (int r = 0; r < 4; r++) begin
      int k = $urandom_range(1, 20);
      set_all(-1);
      for (int j = 0; j < k; j++) ovr[$urandom_range(1, NP)] = $urandom_range(0, 15);
      run_sweep($sformatf("rand%0d", r), bit'($urandom_range(0, 1)));
    end
    set_all(0);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    c = 0;
    while (i0.enc_in != 100 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reach", i0.enc_in, 100);
    set_abort(1'b1);
    @(negedge clk);
    set_abort(1'b0);
    chk("abort_ctl", {i0.busy, i0.done, i0.enc_in, i1.busy, i1.done, i1.enc_in}, '0);
    chk("abort_hold", {i0.err_cnt, i0.fail_vld, i0.first_fail_pat, i0.first_fail_val}, {IN_W'(98), 1'b1, IN_W'(2), OUT_W'(0)});
    set_start(1'b1);
    set_abort(1'b1);
    @(negedge clk);
    set_start(1'b0);
    set_abort(1'b0);
    @(negedge clk);
    chk("abort_start", {i0.busy, i1.busy, i0.enc_in}, '0);
    chk("abort_start_hold", i0.err_cnt, 98);
    set_all(-1);
    run_sweep("post_abort", 1'b0);
    set_all(0);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    c = 0;
    while (i0.enc_in != 50 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk("pre_rst", {i0.busy, i0.enc_in, i0.err_cnt}, {1'b1, IN_W'(50), IN_W'(48)});
    rst_n = 1'b0;
    #1;
    chk("async_rst_s2", {i0.busy, i0.done, i0.pass, i0.fail_vld, i0.err_cnt, i0.first_fail_pat, i0.first_fail_val, i0.enc_in}, '0);
    chk("async_rst_s0", {i1.busy, i1.done, i1.pass, i1.fail_vld, i1.err_cnt, i1.first_fail_pat, i1.first_fail_val, i1.enc_in}, '0);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_quiet", {i0.busy, i0.done, i0.enc_in, i1.busy, i1.done, i1.enc_in}, '0);
    set_all(-1);
    run_sweep("post_rst", 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/encd_bist_ctrl.md
ENCD_BIST_CTRL -- requirements
Module: encd_bist_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 10, the encoder input width.
REQ-002 SHALL have parameter OUT_W, default 4, the encoder output width; it must satisfy 2^OUT_W >= IN_W.
REQ-003 SHALL have parameter SETTLE, default 2, the number of wait cycles between applying a pattern and sampling the result (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  begin a sweep; sampled in IDLE or DONE only.
REQ-007 SHALL have port abort  input  1  terminate a sweep; sampled in any state.
REQ-008 SHALL have port enc_in  output  IN_W  registered pattern driven to the priority encoder under test.
REQ-009 SHALL have port enc_out  input  OUT_W  encoder result returned from the device under test.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port done  output  1  high from sweep completion until the next start.
REQ-012 SHALL have port pass  output  1  valid with done; high when err_cnt is 0.
REQ-013 SHALL have port err_cnt  output  IN_W  count of mismatching patterns, saturating at all-ones.
REQ-014 SHALL have port fail_vld  output  1  high once at least one mismatch has been recorded in the current sweep.
REQ-015 SHALL have port first_fail_pat  output  IN_W  pattern of the first mismatch.
REQ-016 SHALL have port first_fail_val  output  OUT_W  enc_out value captured at the first mismatch.

Function
REQ-017 The block SHALL implement the FSM states IDLE, APPLY, WAIT, CHECK and DONE.
REQ-018 IDLE/DONE with start=1 and abort=0 SHALL clear err_cnt, fail_vld, first_fail_pat, first_fail_val and done, load pat=1, and go to APPLY.
REQ-019 APPLY SHALL drive enc_in=pat and load the settle counter with SETTLE; next state is WAIT if SETTLE>0, else CHECK.
REQ-020 WAIT SHALL decrement the settle counter each cycle and go to CHECK on the cycle it reaches 1.
REQ-021 CHECK SHALL compare enc_out with golden(pat), where golden(pat) is the bit index of the most significant set bit of pat, computed internally in OUT_W bits.
REQ-022 Mismatch in CHECK SHALL increment err_cnt, saturating at 2^IN_W-1.
REQ-023 The first mismatch of a sweep SHALL set fail_vld=1 and capture pat and enc_out; later mismatches SHALL NOT overwrite the captured values.
REQ-024 CHECK SHALL go to DONE if pat = 2^IN_W-1; otherwise it SHALL set pat=pat+1 and go to APPLY.
REQ-025 Pattern 0 (no defined encoder result) SHALL never be applied; the sweep covers exactly 2^IN_W-1 patterns.
REQ-026 Each pattern SHALL take SETTLE+2 cycles, so done rises (2^IN_W-1)*(SETTLE+2) cycles after the edge that samples start.
REQ-027 Entering DONE SHALL set done=1, busy=0, enc_in=0, and pass = (err_cnt==0).
REQ-028 busy SHALL be 1 in APPLY, WAIT and CHECK, and 0 otherwise.
REQ-029 start asserted while busy SHALL be ignored.
REQ-030 abort=1 in APPLY, WAIT or CHECK SHALL force IDLE on the next edge with enc_in=0, busy=0 and done=0; the result registers SHALL hold their last values.
REQ-031 abort and start asserted in the same cycle SHALL be resolved in favour of abort; the FSM stays in or returns to IDLE.
REQ-032 The comparison SHALL be a bitwise equality over all OUT_W bits, with no masking.

Reset
REQ-033 rst_n=0 SHALL immediately force the following, regardless of clk:
  - state=IDLE, pat=0, enc_in=0
  - busy=0, done=0, pass=0, fail_vld=0
  - err_cnt=0, first_fail_pat=0, first_fail_val=0
REQ-034 Reset asserted mid-sweep SHALL discard the sweep; after release, no activity SHALL occur until a new start.

Verification
REQ-035 Fault-free encoder model, defaults, start pulse -> done after 4092 cycles; err_cnt=0, pass=1, fail_vld=0.
REQ-036 Model returns 4'd15 only for input 10'd11 (trigger pattern) -> err_cnt=1, pass=0, first_fail_pat=11, first_fail_val=15.
REQ-037 enc_out stuck at 0 -> err_cnt=1022, first_fail_pat=2, first_fail_val=0.
REQ-038 abort at pattern 100 -> IDLE next cycle, busy=0, done=0, enc_in=0; a following start gives a full clean sweep with err_cnt=0.
REQ-039 rst_n pulsed low mid-WAIT with no clock edge -> all outputs are 0 immediately; start pulsed while busy -> no restart and no change in the cycle count.
REQ-040 SETTLE=0 -> done after 2046 cycles with identical results.
